// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the shared iterative restoring divider:
//   controller state encoding, default operand width and the quotient
//   pattern reported for a divide-by-zero.
package div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DEF_WIDTH = 8;

  // Widest operand the divide-by-zero pattern below can cover.
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor (all ones); users slice it to WIDTH.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = {MAX_WIDTH{1'b1}};

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step
//   One restoring-division iteration, purely combinational.
//   Ports:
//     i_rem   - partial remainder before the step
//     i_quot  - shift register (unconsumed dividend bits / quotient bits so far)
//     i_dvs   - divisor
//     o_rem   - partial remainder after the step
//     o_quot  - shift register after the step (new quotient bit in the LSB)
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_d;

  // Bring in the next dividend bit, then try to subtract the divisor.
  // The partial remainder is always below the divisor, so w_t fits WIDTH+1 bits.
  assign w_t = {i_rem, i_quot[WIDTH-1]};
  assign w_d = w_t - {1'b0, i_dvs};

  // Keep the difference when it did not borrow, otherwise restore.
  always_comb begin
    o_rem  = w_t[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], 1'b0};
    if (w_d[WIDTH] == 1'b0) begin
      o_rem  = w_d[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b1};
    end else begin
      o_rem  = w_t[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one iterative restoring divider between two requesters.
//   Round-robin arbitration in IDLE, one quotient bit per cycle in CALC,
//   result held in DONE until the consumer accepts it.
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     req0/dvd0/dvs0, gnt0       - requester 0 request, operands, one-cycle grant
//     req1/dvd1/dvs1, gnt1       - requester 1 request, operands, one-cycle grant
//     out_valid, out_ready       - result handshake
//     out_id, quot, rem, dbz     - owner, quotient, remainder, divide-by-zero
//     busy                       - controller not in IDLE
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] dvd0,
  input  logic [WIDTH-1:0] dvs0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dvd1,
  input  logic [WIDTH-1:0] dvs1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_gnt;
  logic             r_out_id;
  logic             r_valid;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_grant;
  logic [WIDTH-1:0] w_sel_dvd;
  logic [WIDTH-1:0] w_sel_dvs;
  logic             w_sel_dbz;
  logic             w_cnt_zero;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quot;

  // Arbiter: port 1 wins when alone, or when both ask and port 0 was served last.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      if (req1 && (!req0 || (r_last_gnt == 1'b0))) begin
        w_gnt1 = 1'b1;
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_grant    = w_gnt0 | w_gnt1;
  assign w_sel_dvd  = w_gnt1 ? dvd1 : dvd0;
  assign w_sel_dvs  = w_gnt1 ? dvs1 : dvs0;
  assign w_sel_dbz  = (w_sel_dvs == {WIDTH{1'b0}});
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_quot (w_step_quot)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a consumed result always returns through IDLE before
  // the next grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = w_sel_dbz ? DONE : CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (w_cnt_zero) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = CALC;
        end
      end
      DONE: begin
        if (r_valid && out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= CNT_ZERO;
      r_last_gnt <= 1'b1;
      r_out_id   <= 1'b0;
      r_valid    <= 1'b0;
      r_dbz      <= 1'b0;
      r_quot     <= {WIDTH{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_dvs      <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_last_gnt <= w_gnt1;
            r_out_id   <= w_gnt1;
            r_dvs      <= w_sel_dvs;
            r_dbz      <= w_sel_dbz;
            if (w_sel_dbz) begin
              r_quot  <= DBZ_QUOT[WIDTH-1:0];
              r_rem   <= w_sel_dvd;
              r_valid <= 1'b1;
              r_cnt   <= CNT_ZERO;
            end else begin
              r_quot  <= w_sel_dvd;
              r_rem   <= {WIDTH{1'b0}};
              r_cnt   <= CNT_LAST;
            end
          end
        end
        CALC: begin
          // The step still runs on the final count.
          r_rem  <= w_step_rem;
          r_quot <= w_step_quot;
          if (w_cnt_zero) begin
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign out_valid = r_valid;
  assign out_id    = r_out_id;
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign dbz       = r_dbz;
  assign busy      = (r_state != IDLE);

endmodule
